float_accum_sequencer: RTL and testbench

- Controller that sequences one streaming float accumulator unit (run/running/stride/delay interface, fixed output latency) through a batch of back-to-back reductions.
- Latches a job configuration on start, issues the run pulse, waits out the start delay, streams N elements per reduction for M reductions, drains the pipeline and flags each reduction result with a valid strobe.
- Sits between a contiguous input stream source and the accumulator, inside a Versat accelerator unit.

---
 rtl/float_accum_sequencer.sv | 158 +++++++++++++++
 tb/tb_float_accum_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/float_accum_sequencer.sv
// Sequences a streaming float accumulator through a batch of back-to-back
// reductions: latch job config, pulse run, wait out the start delay, stream
// N elements per reduction for M reductions, drain, and flag each result.
module float_accum_sequencer #(
  parameter int DATA_W   = 32,
  parameter int STRIDE_W = 16,
  parameter int DELAY_W  = 7,
  parameter int CNT_W    = 16,
  parameter int LATENCY  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [STRIDE_W-1:0] cfg_lenMinusOne,
  input  logic [CNT_W-1:0]    cfg_numReductions,
  input  logic [DELAY_W-1:0]  cfg_delay,
  output logic                busy,
  output logic                done,
  output logic                error,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic                acc_run,
  output logic                acc_running,
  output logic [STRIDE_W-1:0] acc_strideMinusOne,
  output logic [DELAY_W-1:0]  acc_delay0,
  output logic [DATA_W-1:0]   acc_in0,
  input  logic [31:0]         acc_out0,
  output logic                out_valid,
  output logic [31:0]         out_data
);

  localparam int DRN_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, ARM, WAIT, STREAM, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [STRIDE_W-1:0] len_q;
  logic [CNT_W-1:0]    num_q;
  logic [DELAY_W-1:0]  dly_q;
  logic [STRIDE_W-1:0] elem_q;
  logic [CNT_W-1:0]    red_q;
  logic [DELAY_W-1:0]  wait_q;
  logic [DRN_W-1:0]    drain_q;
  logic [LATENCY-1:0]  vsr_q;
  logic                err_q;
  logic                zdone_q;

  logic accept, underflow, last_elem, last_red, wait_last, drain_last, push;

  assign accept     = (state_q == STREAM) && in_valid;
  assign underflow  = (state_q == STREAM) && !in_valid;
  assign last_elem  = (elem_q == len_q);
  assign last_red   = (red_q == num_q - CNT_W'(1));
  assign wait_last  = (wait_q == dly_q - DELAY_W'(1));
  assign drain_last = (drain_q == DRN_W'(LATENCY - 1));
  assign push       = accept && last_elem;

  assign out_valid          = vsr_q[LATENCY-1];
  assign out_data           = out_valid ? acc_out0 : '0;
  assign acc_strideMinusOne = len_q;
  assign acc_delay0         = dly_q;
  assign error              = err_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start && (cfg_numReductions != '0)) state_d = ARM;
      ARM:    state_d = (dly_q == '0) ? STREAM : WAIT;
      WAIT:   if (wait_last) state_d = STREAM;
      STREAM: begin
        if (underflow)                          state_d = IDLE;
        else if (push && last_red)              state_d = DRAIN;
      end
      DRAIN:  if (drain_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; stream handshake follows in_valid directly
  always_comb begin
    busy        = (state_q != IDLE);
    acc_run     = 1'b0;
    acc_running = 1'b0;
    in_ready    = 1'b0;
    acc_in0     = '0;
    done        = zdone_q;
    unique case (state_q)
      ARM:    acc_run = 1'b1;
      WAIT:   acc_running = 1'b1;
      STREAM: begin
        in_ready    = in_valid;
        acc_running = in_valid;
        acc_in0     = in_valid ? in_data : '0;
        if (!in_valid) done = 1'b1;
      end
      DRAIN: begin
        acc_running = 1'b1;
        if (drain_last) done = 1'b1;
      end
      default: ;
    endcase
  end

  // Config latch, counters, error flag and result-valid pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      num_q   <= '0;
      dly_q   <= '0;
      elem_q  <= '0;
      red_q   <= '0;
      wait_q  <= '0;
      drain_q <= '0;
      vsr_q   <= '0;
      err_q   <= 1'b0;
      zdone_q <= 1'b0;
    end else begin
      zdone_q <= (state_q == IDLE) && start && (cfg_numReductions == '0);

      if ((state_q == IDLE) && start) begin
        len_q <= cfg_lenMinusOne;
        num_q <= cfg_numReductions;
        dly_q <= cfg_delay;
        err_q <= 1'b0;
      end else if (underflow) begin
        err_q <= 1'b1;
      end

      wait_q  <= (state_q == WAIT)  ? wait_q + DELAY_W'(1) : '0;
      drain_q <= (state_q == DRAIN) ? drain_q + DRN_W'(1)  : '0;

      if (state_q == ARM) begin
        elem_q <= '0;
        red_q  <= '0;
      end else if (accept) begin
        if (last_elem) begin
          elem_q <= '0;
          red_q  <= red_q + CNT_W'(1);
        end else begin
          elem_q <= elem_q + STRIDE_W'(1);
        end
      end

      // Results still in flight when a job aborts are discarded
      if (underflow)        vsr_q <= '0;
      else if (acc_running) vsr_q <= (vsr_q << 1) | LATENCY'(push);
    end
  end

endmodule

// File: tb/tb_float_accum_sequencer.sv
// Bench for float_accum_sequencer: each job is expanded into an expected
// per-cycle trace from the job timeline, driven cycle by cycle and compared.
module tb_float_accum_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [15:0] cfg_len, cfg_num;
  logic [6:0]  cfg_dly;
  logic        busy, done, error, in_ready, acc_run, acc_running, out_valid;
  logic [31:0] in_data, acc_in0, acc_out0, out_data;
  logic [15:0] acc_stride;
  logic [6:0]  acc_dly;

  float_accum_sequencer #(
    .DATA_W(32), .STRIDE_W(16), .DELAY_W(7), .CNT_W(16), .LATENCY(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_lenMinusOne(cfg_len), .cfg_numReductions(cfg_num), .cfg_delay(cfg_dly),
    .busy(busy), .done(done), .error(error),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .acc_run(acc_run), .acc_running(acc_running),
    .acc_strideMinusOne(acc_stride), .acc_delay0(acc_dly),
    .acc_in0(acc_in0), .acc_out0(acc_out0),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, start, ival;
    logic [31:0] idata, aout;
    logic [15:0] len, num;
    logic [6:0]  dly;
    logic        busy, done, err, rdy, run, runn, ov, chk_ain;
    logic [31:0] ain;
    logic [15:0] xlen;
    logic [6:0]  xdly;
  } cyc_t;

  cyc_t        tr[$];
  cyc_t        cur;
  bit          chk = 1'b0;
  int          cur_c;
  int          n_chk = 0, n_pass = 0;
  logic [15:0] m_len = '0;
  logic [6:0]  m_dly = '0;
  logic        m_err = 1'b0;
  logic [31:0] g_data[$], g_res[$];
  int          st_busy, st_run, st_done, c_run, c_rdy;
  int          ov_c[$];
  logic [31:0] ov_d[$];
  logic        last_err;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @job-cycle %0d: got %h, want %h", nm, cur_c, act, exp);
  endtask

  function automatic cyc_t blank();
    cyc_t t;
    t = '{default: '0};
    t.ival  = 1'($urandom_range(1, 0));
    t.idata = $urandom;
    t.aout  = $urandom;
    t.len   = 16'($urandom);
    t.num   = 16'($urandom);
    t.dly   = 7'($urandom);
    t.xlen  = m_len;
    t.xdly  = m_dly;
    t.err   = m_err;
    return t;
  endfunction

  // Expand one job into its expected trace. Cycle 0 carries start; ARM is
  // cycle 1, streaming starts at 2+D, results show 4 cycles after completion.
  task automatic build_job(input int D, input int L1, input int N, input int uf, input int rr);
    int S, Lm, E, endc, lim, j, oc;
    cyc_t t;
    S = 2 + D; Lm = L1 + 1; E = N * Lm;
    tr.delete();
    if (g_data.size() == 0) for (int i = 0; i < E; i++) g_data.push_back($urandom);
    if (g_res.size() == 0)  for (int i = 0; i < N; i++) g_res.push_back($urandom);
    t = blank(); t.start = 1'b1; t.len = 16'(L1); t.num = 16'(N); t.dly = 7'(D);
    tr.push_back(t);
    m_len = 16'(L1); m_dly = 7'(D); m_err = 1'b0;
    if (N == 0) begin
      t = blank(); t.done = 1'b1; tr.push_back(t);
      t = blank(); tr.push_back(t);
    end else begin
      endc = (uf >= 0) ? S + uf : S + E + 3;
      for (int c = 1; c <= endc; c++) begin
        t = blank();
        t.busy  = 1'b1;
        t.start = ($urandom_range(5, 0) == 0);
        if (c == 1) t.run = 1'b1;
        else if (c < S) begin
          t.runn = 1'b1; t.chk_ain = 1'b1; t.ain = '0;
        end else if (c - S < E) begin
          j = c - S;
          if (uf >= 0 && j == uf) begin
            t.ival = 1'b0; t.done = 1'b1;
          end else begin
            t.ival = 1'b1; t.rdy = 1'b1; t.runn = 1'b1;
            t.idata = g_data[j]; t.chk_ain = 1'b1; t.ain = g_data[j];
          end
        end else begin
          t.runn = 1'b1; t.chk_ain = 1'b1; t.ain = '0; t.done = (c == endc);
        end
        tr.push_back(t);
      end
      lim = (uf >= 0) ? uf : E;
      for (int r = 0; r < N; r++) begin
        j = r * Lm + L1; oc = S + j + 4;
        if (j < lim && oc <= endc) begin
          tr[oc].ov = 1'b1; tr[oc].aout = g_res[r];
        end
      end
      if (uf >= 0) m_err = 1'b1;
      t = blank(); tr.push_back(t);
    end
    if (rr >= 0) begin
      while (tr.size() > rr + 1) void'(tr.pop_back());
      tr[rr].rst = 1'b1;
      m_len = '0; m_dly = '0; m_err = 1'b0;
      t = blank(); tr.push_back(t);
    end
    g_data.delete(); g_res.delete();
  endtask

  task automatic run_trace();
    st_busy = 0; st_run = 0; st_done = 0; c_run = -1; c_rdy = -1;
    ov_c.delete(); ov_d.delete();
    foreach (tr[c]) begin
      @(posedge clk); #1;
      rst = tr[c].rst; start = tr[c].start;
      cfg_len = tr[c].len; cfg_num = tr[c].num; cfg_dly = tr[c].dly;
      in_valid = tr[c].ival; in_data = tr[c].idata; acc_out0 = tr[c].aout;
      cur = tr[c]; cur_c = c; chk = 1'b1;
    end
    @(negedge clk); #1;
    chk = 1'b0;
  endtask

  // Per-cycle comparison against the expected trace entry
  always @(negedge clk) begin
    if (chk) begin
      check("busy",        32'(busy),        32'(cur.busy));
      check("done",        32'(done),        32'(cur.done));
      check("error",       32'(error),       32'(cur.err));
      check("in_ready",    32'(in_ready),    32'(cur.rdy));
      check("acc_run",     32'(acc_run),     32'(cur.run));
      check("acc_running", 32'(acc_running), 32'(cur.runn));
      check("out_valid",   32'(out_valid),   32'(cur.ov));
      check("acc_stride",  32'(acc_stride),  32'(cur.xlen));
      check("acc_delay0",  32'(acc_dly),     32'(cur.xdly));
      if (cur.chk_ain) check("acc_in0", acc_in0, cur.ain);
      if (cur.ov)      check("out_data", out_data, cur.aout);
      st_busy += int'(busy);
      st_done += int'(done);
      if (acc_run) begin st_run++; c_run = cur_c; end
      if (in_ready && c_rdy < 0) c_rdy = cur_c;
      if (out_valid) begin ov_c.push_back(cur_c); ov_d.push_back(out_data); end
      last_err = error;
    end
  end

  initial begin
    cyc_t t;
    int D, L1, N, E, uf, rr, endc;
    rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_num = '0; cfg_dly = '0;
    in_valid = 1'b0; in_data = '0; acc_out0 = '0;
    repeat (2) @(posedge clk);

    // Held in reset: everything at zero
    tr.delete(); t = blank(); t.rst = 1'b1; tr.push_back(t);
    run_trace();

    // 1.0..8.0, two reductions of four; sums 10.0 and 26.0
    g_data = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    g_res  = '{32'h41200000, 32'h41D00000};
    build_job(0, 3, 2, -1, -1); run_trace();
    check("t1_busy_cycles", st_busy, 13);
    check("t1_done_count", st_done, 1);
    check("t1_ov_count", ov_c.size(), 2);
    check("t1_ov_cycle0", ov_c[0], 9);
    check("t1_ov_cycle1", ov_c[1], 13);
    check("t1_sum0", ov_d[0], 32'h41200000);
    check("t1_sum1", ov_d[1], 32'h41D00000);

    // Start delay 5
    build_job(5, 1, 1, -1, -1); run_trace();
    check("t2_run_to_ready", c_rdy - c_run, 6);
    check("t2_ov_count", ov_c.size(), 1);

    // Single-element reductions, back-to-back valids
    g_data = '{32'h40000000, 32'hC0400000, 32'h3F000000, 32'h00000000};
    g_res  = '{32'h40000000, 32'hC0400000, 32'h3F000000, 32'h00000000};
    build_job(3, 0, 4, -1, -1); run_trace();
    check("t3_ov_count", ov_c.size(), 4);
    check("t3_ov_span", ov_c[3] - ov_c[0], 3);
    check("t3_val0", ov_d[0], 32'h40000000);
    check("t3_val1", ov_d[1], 32'hC0400000);
    check("t3_val2", ov_d[2], 32'h3F000000);
    check("t3_val3", ov_d[3], 32'h00000000);

    // Underflow at the third element, then a clean job
    build_job(2, 3, 1, 2, -1); run_trace();
    check("t4_ov_count", ov_c.size(), 0);
    check("t4_done_count", st_done, 1);
    check("t4_error_after", 32'(last_err), 1);
    build_job(1, 2, 2, -1, -1); run_trace();
    check("t4_error_cleared", 32'(last_err), 0);
    check("t4_clean_ov_count", ov_c.size(), 2);

    // Zero reductions
    build_job(0, 5, 0, -1, -1); run_trace();
    check("t5_run_count", st_run, 0);
    check("t5_done_count", st_done, 1);

    // Reset while streaming, then a clean job
    build_job(2, 2, 3, -1, 9); run_trace();
    check("t6_done_count", st_done, 0);
    build_job(0, 1, 2, -1, -1); run_trace();
    check("t6_clean_ov_count", ov_c.size(), 2);

    // Long reduction length
    build_job(0, 300, 2, -1, -1); run_trace();
    check("long_ov_count", ov_c.size(), 2);

    // Randomised jobs
    for (int k = 0; k < 40; k++) begin
      D  = int'($urandom_range(9, 0));
      L1 = int'($urandom_range(6, 0));
      N  = int'($urandom_range(4, 0));
      E  = N * (L1 + 1);
      uf = (N > 0 && $urandom_range(3, 0) == 0) ? int'($urandom_range(E - 1, 0)) : -1;
      endc = (uf >= 0) ? 2 + D + uf : 2 + D + E + 3;
      rr = (N > 0 && $urandom_range(5, 0) == 0) ? int'($urandom_range(endc, 1)) : -1;
      build_job(D, L1, N, uf, rr); run_trace();
    end

    // Maximum reduction count
    build_job(1, 0, 65535, -1, -1); run_trace();
    check("max_ov_count", ov_c.size(), 65535);
    check("max_done_count", st_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
